fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: groups the program counter, instruction fetch and
// redirect signals that pass between the fetch sequencer and its surroundings.
//   master : the fetch sequencer (drives pc_next, pcWEN, iREN, halted, misalign)
//   slave  : the program counter, the icache and the decode/hazard logic
interface fetch_sequencer_if;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
  logic        pcWEN;
  logic        ihit;
  logic        stall;
  logic        halt;
  logic        jr;
  logic        jump;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        iREN;
  logic        halted;
  logic        misalign;

  modport master (
    input  pc_out, ihit, stall, halt, jr, jump, branch_taken,
           jr_target, jump_target, branch_target,
    output pc_next, pcWEN, iREN, halted, misalign
  );

  modport slave (
    output pc_out, ihit, stall, halt, jr, jump, branch_taken,
           jr_target, jump_target, branch_target,
    input  pc_next, pcWEN, iREN, halted, misalign
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: chooses the next PC (sequential or redirect), buffers a
// redirect that arrives while the PC cannot be written, and stops fetching
// for good on halt until reset.
//
// Ports:
//   CLK   - sole clock, rising edge
//   nRST  - synchronous active-low reset
//   bus   - fetch_sequencer_if.master: pc_out/ihit/stall/halt/redirects in,
//           pc_next/pcWEN/iREN/halted/misalign out
//
// Parameter:
//   PC_INC - sequential fetch increment in bytes
//
// Build option:
//   FETCH_SEQ_ALIGN_CHECK_EN - when defined, a misaligned redirect target halts
//   the sequencer and sets misalign; otherwise target bits [1:0] are cleared.
module fetch_sequencer #(
  parameter int unsigned PC_INC = 4
) (
  input logic             CLK,
  input logic             nRST,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {StRun, StPend, StHalted} state_e;

  state_e      state;
  logic [31:0] pend_tgt;
  logic        halted_q;
  logic        misalign_q;

  logic        redir;
  logic [31:0] req_raw;
  logic [31:0] req_tgt;
  logic        bad_tgt;
  logic        write;

  assign redir = bus.jr | bus.jump | bus.branch_taken;

  // jr > jump > branch_taken
  always_comb begin
    req_raw = bus.branch_target;
    if (bus.jr) begin
      req_raw = bus.jr_target;
    end else if (bus.jump) begin
      req_raw = bus.jump_target;
    end
  end

`ifdef FETCH_SEQ_ALIGN_CHECK_EN
  assign req_tgt = req_raw;
  assign bad_tgt = redir & (req_raw[1:0] != 2'b00) & (state != StHalted);
`else
  assign req_tgt = {req_raw[31:2], 2'b00};
  assign bad_tgt = 1'b0;
`endif

  // nRST gating keeps the PC and icache quiet for the whole reset window.
  assign write = nRST & bus.ihit & ~bus.stall & (state != StHalted) & ~bus.halt & ~bad_tgt;

  always_comb begin
    bus.pc_next = bus.pc_out;
    unique case (state)
      StRun:    bus.pc_next = redir ? req_tgt : bus.pc_out + 32'(PC_INC);
      StPend:   bus.pc_next = redir ? req_tgt : pend_tgt;
      StHalted: bus.pc_next = bus.pc_out;
      default:  bus.pc_next = bus.pc_out;
    endcase
  end

  assign bus.pcWEN    = write;
  assign bus.iREN     = nRST & (state != StHalted);
  assign bus.halted   = halted_q;
  assign bus.misalign = misalign_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= StRun;
      pend_tgt   <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state)
        StRun, StPend: begin
          if (bus.halt) begin
            state    <= StHalted;
            halted_q <= 1'b1;
            pend_tgt <= '0;
          end else if (bad_tgt) begin
            state      <= StHalted;
            halted_q   <= 1'b1;
            misalign_q <= 1'b1;
            pend_tgt   <= '0;
          end else if (write) begin
            // Any buffered target was just written through pc_next.
            state <= StRun;
          end else if (redir) begin
            // Newest redirect overwrites whatever was buffered.
            state    <= StPend;
            pend_tgt <= req_tgt;
          end
        end
        StHalted: begin
          state <= StHalted;
        end
        default: begin
          state <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.PC_INC(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        wen;
    logic        chk_pc;
    logic [31:0] pc;
    logic        ren;
    logic        hlt;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", n, f, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs of each cycle against the queued expectation.
  exp_t m;
  always @(negedge CLK) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      cmp(m.name, "pcWEN", 32'(bus.pcWEN), 32'(m.wen));
      cmp(m.name, "iREN", 32'(bus.iREN), 32'(m.ren));
      cmp(m.name, "halted", 32'(bus.halted), 32'(m.hlt));
      cmp(m.name, "misalign", 32'(bus.misalign), 32'(m.mis));
      if (m.chk_pc) cmp(m.name, "pc_next", bus.pc_next, m.pc);
    end
  end

  // Push this cycle's expectation, then advance to just after the next edge.
  task automatic step(input string n, input logic wen, input logic chk_pc,
                      input logic [31:0] pc, input logic ren, input logic hlt,
                      input logic mis);
    exp_t e;
    e.name = n; e.wen = wen; e.chk_pc = chk_pc; e.pc = pc;
    e.ren = ren; e.hlt = hlt; e.mis = mis;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.ihit = 1'b0; bus.stall = 1'b0; bus.halt = 1'b0;
    bus.jr = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
    bus.jr_target = '0; bus.jump_target = '0; bus.branch_target = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    bus.pc_out = 32'h0;
    nRST = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;

    // Reset window
    bus.ihit = 1'b1;
    step("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Sequential fetch
    nRST = 1'b1;
    bus.pc_out = 32'h0; step("seq0", 1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    bus.pc_out = 32'h4; step("seq1", 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    bus.pc_out = 32'h8; step("seq2", 1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 1'b0);

    // Jump while ihit=0 -> buffered, written on the later ihit
    clr(); bus.pc_out = 32'h100; bus.jump = 1'b1; bus.jump_target = 32'h400;
    step("jmp_req", 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    clr(); step("jmp_pend", 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    bus.ihit = 1'b1; step("jmp_wr", 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    bus.pc_out = 32'h400; step("jmp_seq", 1'b1, 1'b1, 32'h404, 1'b1, 1'b0, 1'b0);

    // jr beats branch
    clr(); bus.ihit = 1'b1; bus.pc_out = 32'h404;
    bus.jr = 1'b1; bus.jr_target = 32'h800;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    step("prio", 1'b1, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0);

    // Branch under a three-cycle stall
    clr(); bus.ihit = 1'b1; bus.stall = 1'b1; bus.pc_out = 32'h800;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h300;
    step("stall1", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    step("stall2", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    step("stall3", 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b0;
    step("stall_wr", 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    bus.pc_out = 32'h300;
    step("stall_seq", 1'b1, 1'b1, 32'h304, 1'b1, 1'b0, 1'b0);

    // Wrap-around
    bus.pc_out = 32'hFFFF_FFFC;
    step("wrap", 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    // Newest redirect overwrites the buffered one
    clr(); bus.pc_out = 32'h400; bus.jump = 1'b1; bus.jump_target = 32'h500;
    step("new_req", 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    clr(); bus.branch_taken = 1'b1; bus.branch_target = 32'h600;
    step("new_over", 1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    clr(); bus.ihit = 1'b1;
    step("new_wr", 1'b1, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect target
    clr(); bus.ihit = 1'b1; bus.pc_out = 32'h1000;
    bus.jump = 1'b1; bus.jump_target = 32'h402;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    step("mis_req", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    clr(); bus.ihit = 1'b1;
    step("mis_halt", 1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 1'b1);
    nRST = 1'b0;
    step("mis_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    nRST = 1'b1;
`else
    step("mis_req", 1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
`endif

    // Halt beats a simultaneous jump and is terminal
    clr(); bus.ihit = 1'b1; bus.pc_out = 32'h600;
    bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h40;
    step("halt_req", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    clr(); bus.ihit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.jump = i[0]; bus.jump_target = 32'h40;
      step("halted", 1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
    end

    // Reset out of HALTED
    clr(); nRST = 1'b0;
    step("halt_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    nRST = 1'b1; bus.pc_out = 32'h20;
    step("post_rst", 1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0);

    // Reset in PEND drops the buffered target
    bus.jump = 1'b1; bus.jump_target = 32'h700;
    step("pend_req", 1'b0, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    clr(); nRST = 1'b0;
    step("pend_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    nRST = 1'b1; bus.ihit = 1'b1;
    step("pend_drop", 1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0);

    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
